// File: rtl/alu_pkg.sv
// Shared ALU control-word definitions used by decode-side control and the execute unit.
package alu_pkg;

    localparam int CTRL_W      = 8;
    localparam int CTRL_EN_BIT = 7;
    localparam int OP_W        = 7;

    // One-hot opcodes carried in ctrl[6:0]
    localparam logic [OP_W-1:0] OP_ADD = 7'b0000001;
    localparam logic [OP_W-1:0] OP_SUB = 7'b0000010;
    localparam logic [OP_W-1:0] OP_AND = 7'b0000100;
    localparam logic [OP_W-1:0] OP_OR  = 7'b0001000;
    localparam logic [OP_W-1:0] OP_NOT = 7'b0010000;
    localparam logic [OP_W-1:0] OP_SHR = 7'b0100000;
    localparam logic [OP_W-1:0] OP_SHL = 7'b1000000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True when exactly one bit of the opcode field is set
    function automatic logic is_onehot(input logic [OP_W-1:0] v);
        return (v != '0) && ((v & (v - 7'd1)) == '0);
    endfunction

endpackage

// File: rtl/alu_shift_engine.sv
// Iterative one-bit-per-cycle logical shifter: holds the working value, the
// remaining count and the direction, and exposes the next step combinationally
// so the caller can capture the final value on the same edge it is produced.
module alu_shift_engine #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_left,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_step,
    output logic [WIDTH-1:0]   o_next_work,
    output logic               o_carry,
    output logic               o_done
);

    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;

    // One-bit shift of the working value with zero fill; carry is the bit pushed out
    always_comb begin
        o_next_work = r_work;
        o_carry     = 1'b0;
        if (r_left) begin
            o_next_work = {r_work[WIDTH-2:0], 1'b0};
            o_carry     = r_work[WIDTH-1];
        end else begin
            o_next_work = {1'b0, r_work[WIDTH-1:1]};
            o_carry     = r_work[0];
        end
    end

    // The step that consumes the last count is the one that completes the shift
    assign o_done = i_step && (r_cnt == SHAMT_W'(1));

    // Load on accept, then advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_left <= 1'b0;
        end else if (i_load) begin
            r_work <= i_data;
            r_cnt  <= i_shamt;
            r_left <= i_left;
        end else if (i_step) begin
            r_work <= o_next_work;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR/NOT, iterative shifts that
// stall the input handshake, registered result with Z/N/C flags and an error
// pulse for malformed control words.
module alu_execute_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  ctrl,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               out_valid,
    output logic [WIDTH-1:0]   result,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               err
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_out_valid;
    logic               r_err;
    logic [WIDTH-1:0]   r_result;
    logic               r_z;
    logic               r_n;
    logic               r_c;

    logic [OP_W-1:0]    w_op;
    logic               w_enable;
    logic               w_legal;
    logic               w_accept;
    logic               w_is_shift;
    logic               w_start_shift;
    logic               w_step;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_shift_carry;
    logic               w_shift_done;

    assign w_op     = ctrl[OP_W-1:0];
    assign w_enable = ctrl[CTRL_EN_BIT];
    assign w_legal  = is_onehot(w_op);

    // Ready only while idle; held low during reset so nothing sees a handshake then
    assign in_ready      = rst_n && (r_state == ST_IDLE);
    assign w_accept      = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_is_shift    = (w_op == OP_SHR) || (w_op == OP_SHL);
    assign w_start_shift = w_accept && w_enable && w_legal && w_is_shift && (shamt != '0);
    assign w_step        = (r_state == ST_SHIFT) && !flush;

    alu_shift_engine #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_start_shift),
        .i_left      (w_op == OP_SHL),
        .i_data      (op_a),
        .i_shamt     (shamt),
        .i_step      (w_step),
        .o_next_work (w_shift_next),
        .o_carry     (w_shift_carry),
        .o_done      (w_shift_done)
    );

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1
    always_comb begin
        w_b_eff   = op_b;
        w_cin     = 1'b0;
        if (w_op == OP_SUB) begin
            w_b_eff = ~op_b;
            w_cin   = 1'b1;
        end
        w_sum     = {1'b0, op_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            OP_AND:         w_alu_res = op_a & op_b;
            OP_OR:          w_alu_res = op_a | op_b;
            OP_NOT:         w_alu_res = ~op_a;
            OP_SHR, OP_SHL: w_alu_res = op_a;   // zero-length shift passes A through
            default:        w_alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: enter SHIFT on a multi-cycle shift, leave on completion or flush
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_shift) w_state_next = ST_SHIFT;
            ST_SHIFT: if (flush || w_shift_done) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Result/flag registers; out_valid and err are one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            if (w_accept && w_enable) begin
                if (!w_legal) begin
                    // Malformed op: report it, zero the result, keep previous flags
                    r_out_valid <= 1'b1;
                    r_err       <= 1'b1;
                    r_result    <= '0;
                end else if (!w_start_shift) begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_alu_res;
                    r_z         <= (w_alu_res == '0);
                    r_n         <= w_alu_res[WIDTH-1];
                    r_c         <= w_alu_c;
                end
            end else if (w_shift_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_shift_next;
                r_z         <= (w_shift_next == '0);
                r_n         <= w_shift_next[WIDTH-1];
                r_c         <= w_shift_carry;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit: each task drives one scenario and
// compares {in_ready, out_valid, err, Z, N, C, result} against hand-computed values.
module tb_alu_execute_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  ctrl;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  shamt;
    logic        flush;
    logic        out_valid;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        err;

    int checks;
    int failures;

    // Observed bundle: {in_ready, out_valid, err, Z, N, C, result}
    logic [21:0] obs;
    assign obs = {in_ready, out_valid, err, flag_z, flag_n, flag_c, result};

    alu_execute_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL reset_held obs=%h required=%h", obs, 22'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b1, 21'h0}) begin
            failures++;
            $display("FAIL reset_release obs=%h required=%h", obs, {1'b1, 21'h0});
        end
        $display("txn reset in_ready=%b result=%h", in_ready, result);
    endtask

    task automatic test_add;
        in_valid = 1'b1; ctrl = 8'h81; op_a = 16'hFFFF; op_b = 16'h0001; shamt = 4'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL add_wrap obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000});
        end
        $display("txn add a=ffff b=0001 result=%h z=%b n=%b c=%b", result, flag_z, flag_n, flag_c);
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL add_hold obs=%h required=%h", obs, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000});
        end
    endtask

    task automatic test_sub;
        in_valid = 1'b1; ctrl = 8'h82; op_a = 16'h0003; op_b = 16'h0005;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE}) begin
            failures++;
            $display("FAIL sub_borrow obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE});
        end
        $display("txn sub a=0003 b=0005 result=%h c=%b", result, flag_c);
        op_a = 16'h0005; op_b = 16'h0003;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002}) begin
            failures++;
            $display("FAIL sub_noborrow obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002});
        end
        $display("txn sub a=0005 b=0003 result=%h c=%b", result, flag_c);
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002}) begin
            failures++;
            $display("FAIL sub_hold obs=%h required=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002});
        end
    endtask

    task automatic test_logic_back_to_back;
        in_valid = 1'b1; ctrl = 8'h84; op_a = 16'hF0F0; op_b = 16'hFF00;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF000}) begin
            failures++;
            $display("FAIL and obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF000});
        end
        $display("txn and result=%h", result);
        ctrl = 8'h88; op_a = 16'h00F0; op_b = 16'h0F00;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0FF0}) begin
            failures++;
            $display("FAIL or obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0FF0});
        end
        $display("txn or result=%h", result);
        ctrl = 8'h90; op_a = 16'hFFFF; op_b = 16'h1234;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL not obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        end
        $display("txn not result=%h z=%b", result, flag_z);
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL logic_idle obs=%h required=%h", obs, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        end
    endtask

    task automatic test_shl;
        in_valid = 1'b1; ctrl = 8'hC0; op_a = 16'h8001; op_b = 16'h0000; shamt = 4'd3;
        tick();
        // Present a pending ADD during the shift: must wait until in_ready returns
        ctrl = 8'h81; op_a = 16'h0001; op_b = 16'h0001; shamt = 4'd0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL shl_busy0 obs=%h required=%h", obs, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        end
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
                failures++;
                $display("FAIL shl_busy%0d obs=%h required=%h", i, obs, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
            end
        end
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008}) begin
            failures++;
            $display("FAIL shl_done obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008});
        end
        $display("txn shl a=8001 n=3 result=%h c=%b", result, flag_c);
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002}) begin
            failures++;
            $display("FAIL held_add obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002});
        end
        $display("txn add(held) result=%h", result);
    endtask

    task automatic test_shr;
        in_valid = 1'b1; ctrl = 8'hA0; op_a = 16'h0003; shamt = 4'd1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002}) begin
            failures++;
            $display("FAIL shr_busy obs=%h required=%h", obs, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001}) begin
            failures++;
            $display("FAIL shr_done obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001});
        end
        $display("txn shr a=0003 n=1 result=%h c=%b", result, flag_c);
        in_valid = 1'b1; ctrl = 8'hA0; op_a = 16'h8005; shamt = 4'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8005}) begin
            failures++;
            $display("FAIL shr_zero obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8005});
        end
        $display("txn shr a=8005 n=0 result=%h", result);
    endtask

    task automatic test_illegal_nop;
        in_valid = 1'b1; ctrl = 8'h83; op_a = 16'h0001; op_b = 16'h0001;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL illegal_multi obs=%h required=%h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        $display("txn illegal ctrl=83 err=%b result=%h", err, result);
        ctrl = 8'h80;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL illegal_zero obs=%h required=%h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        $display("txn illegal ctrl=80 err=%b", err);
        ctrl = 8'h01; op_a = 16'h0005; op_b = 16'h0005;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL nop obs=%h required=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        $display("txn nop ctrl=01 out_valid=%b", out_valid);
    endtask

    task automatic test_flush;
        logic seen;
        in_valid = 1'b1; ctrl = 8'hA0; op_a = 16'hFFFF; shamt = 4'd5;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL flush_busy obs=%h required=%h", obs, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL flush_shift obs=%h required=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_late_valid obs=%b required=%b", seen, 1'b0);
        end
        $display("txn flush_shift in_ready=%b result=%h", in_ready, result);
        in_valid = 1'b1; ctrl = 8'h81; op_a = 16'h0001; op_b = 16'h0001; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL flush_idle obs=%h required=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL flush_idle_after obs=%h required=%h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        end
        $display("txn flush_idle out_valid=%b result=%h", out_valid, result);
    endtask

    task automatic test_reset_midshift;
        logic seen;
        in_valid = 1'b1; ctrl = 8'hC0; op_a = 16'h0001; shamt = 4'd10;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL reset_async obs=%h required=%h", obs, 22'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b1, 21'h0}) begin
            failures++;
            $display("FAIL reset_mid_release obs=%h required=%h", obs, {1'b1, 21'h0});
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_lost_op obs=%b required=%b", seen, 1'b0);
        end
        $display("txn reset_midshift in_ready=%b result=%h", in_ready, result);
        in_valid = 1'b1; ctrl = 8'h81; op_a = 16'h7FFF; op_b = 16'h0001;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000}) begin
            failures++;
            $display("FAIL add_after_reset obs=%h required=%h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000});
        end
        $display("txn add a=7fff b=0001 result=%h n=%b", result, flag_n);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ctrl     = 8'h00;
        op_a     = 16'h0000;
        op_b     = 16'h0000;
        shamt    = 4'd0;
        flush    = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic_back_to_back();
        test_shl();
        test_shr();
        test_illegal_nop();
        test_flush();
        test_reset_midshift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
